// File: rtl/seq_normalizer_if.sv
// Handshake/data bundle for seq_normalizer: word in on i_valid/o_ready, result out on o_valid/i_ready.
// The master modport is the side that supplies the word and consumes the result.
interface seq_normalizer_if #(
  parameter int BIT = 8
) ();
  localparam int SW = $clog2(BIT);

  logic           i_valid;
  logic           o_ready;
  logic [BIT-1:0] i_data;
  logic           i_sel_left;
  logic           o_valid;
  logic           i_ready;
  logic [BIT-1:0] o_data;
  logic [SW-1:0]  o_shifter;
  logic           o_zero;

  modport slave (
    input  i_valid, i_data, i_sel_left, i_ready,
    output o_ready, o_valid, o_data, o_shifter, o_zero
  );

  modport master (
    output i_valid, i_data, i_sel_left, i_ready,
    input  o_ready, o_valid, o_data, o_shifter, o_zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts a word toward its MSB (left) or LSB (right) until that bit is set,
// reporting the shift count. Define NORM_FAST_EN to allow two-bit steps when two zeros lead.
module seq_normalizer #(
  parameter int BIT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  seq_normalizer_if.slave bus
);
  localparam int SW = $clog2(BIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BIT-1:0] data_q, data_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           zero_q, zero_d;
  logic           target_bit;
`ifdef NORM_FAST_EN
  logic           inner_bit;
`endif

  // dir_q=1 normalizes toward the MSB, dir_q=0 toward the LSB.
  assign target_bit = dir_q ? data_q[BIT-1] : data_q[0];
`ifdef NORM_FAST_EN
  assign inner_bit  = dir_q ? data_q[BIT-2] : data_q[1];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          data_d  = bus.i_data;
          dir_d   = bus.i_sel_left;
          cnt_d   = '0;
          zero_d  = (bus.i_data == '0);
          state_d = (bus.i_data == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (target_bit) begin
          state_d = DONE;
`ifdef NORM_FAST_EN
        end else if (!inner_bit) begin
          data_d = dir_q ? (data_q << 2) : (data_q >> 2);
          cnt_d  = cnt_q + SW'(2);
`endif
        end else begin
          data_d = dir_q ? (data_q << 1) : (data_q >> 1);
          cnt_d  = cnt_q + SW'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.o_ready   = (state_q == IDLE);
  assign bus.o_valid   = (state_q == DONE);
  assign bus.o_data    = data_q;
  assign bus.o_shifter = cnt_q;
  assign bus.o_zero    = zero_q;
endmodule

// File: doc/seq_normalizer.md
Name: seq_normalizer

Overview:
- Multi-cycle normalizer; the inverse of the combinational barrel shifter.
- The barrel shifter applies a known shift amount. This block takes a data word and discovers the shift amount that normalizes it, shifting one bit per cycle.
- Left mode shifts until bit BIT-1 is set; right mode shifts until bit 0 is set.
- Sits in front of the barrel shifter. Feeding {o_data, opposite direction, o_shifter} into the barrel shifter reproduces the original word.

Parameters:
- BIT, 8, data width in bits; must be a power of 2 and at least 4.
- SW, $clog2(BIT), width of the shift count (localparam).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  input word valid.
- o_ready  output  1  block can accept a word; high only in IDLE.
- i_data  input  BIT  word to normalize.
- i_sel_left  input  1  1 = left normalize (MSB target), 0 = right normalize (LSB target); sampled on accept.
- o_valid  output  1  result valid; high only in DONE.
- i_ready  input  1  downstream accepts the result.
- o_data  output  BIT  normalized word.
- o_shifter  output  SW  number of bit positions shifted.
- o_zero  output  1  input word was all zeros.

Behaviour:
- Reset (async, any state): state goes to IDLE. o_valid=0, o_data=0, o_shifter=0, o_zero=0. o_ready=1 once reset is released.
- States: IDLE, SEARCH, DONE. Registered state; 2 state bits.
- IDLE:
  - o_ready=1.
  - Accept on a rising edge with i_valid=1: load data_r=i_data, dir_r=i_sel_left, cnt=0.
  - If i_data==0: go to DONE with o_zero=1, o_data=0, o_shifter=0.
  - Otherwise: go to SEARCH with o_zero=0.
- SEARCH, each edge:
  - Target bit is data_r[BIT-1] if dir_r=1, else data_r[0].
  - Target bit set: go to DONE.
  - Target bit clear: data_r shifts by 1 toward the target (zero fill) and cnt increments.
  - cnt can never exceed BIT-1, because the word is nonzero.
- DONE:
  - o_valid=1; o_data=data_r, o_shifter=cnt, o_zero as latched.
  - Outputs stay stable while i_ready=0.
  - On an edge with i_ready=1: go to IDLE. o_valid drops and o_ready rises in the next cycle.
- Latency, nonzero word with k leading (left) or trailing (right) zeros: o_valid asserts k+1 cycles after the accept edge.
- Latency, zero word: o_valid asserts 0 cycles after the accept edge.
- Throughput: at most one word per k+3 cycles. There is no accept in DONE, so a simultaneous i_valid and result handshake never loses data; the new word waits for IDLE.
- i_data and i_sel_left are don't-care outside the accept edge. Changing them mid-SEARCH has no effect.
- Reset mid-SEARCH or mid-DONE aborts the word; no o_valid is produced for it.
- Invariant: o_data with dir_r=1 has o_data[BIT-1]=1; with dir_r=0 it has o_data[0]=1 (unless o_zero=1).
- Invariant: barrel-shifting o_data by o_shifter in the opposite direction equals the accepted i_data.

Optional Feature:
- Macro: NORM_FAST_EN.
- Defined:
  - In SEARCH, if the target bit and the next bit inward are both 0, shift by 2 and add 2 to cnt in one cycle. If only the target bit is 0, shift by 1. If the target bit is set, go to DONE.
  - Latency becomes ceil(k/2)+1 cycles.
  - o_data, o_shifter and o_zero are identical to the undefined build.
- Undefined: exactly one-bit steps, as above.

Test Plan:
- Left, i_data=8'b0001_0110 -> o_data=8'b1011_0000, o_shifter=3, o_zero=0, o_valid 4 cycles after accept (3 with NORM_FAST_EN).
- Right, i_data=8'b0110_1000 -> o_data=8'b0000_1101, o_shifter=3. Barrel-shift it left by 3 -> 8'b0110_1000 is recovered.
- Left 8'b1000_0000 -> o_shifter=0, 1-cycle latency. Right 8'b1000_0000 -> o_data=8'b0000_0001, o_shifter=7, 8-cycle latency (5 with NORM_FAST_EN).
- i_data=8'h00, either direction -> o_zero=1, o_data=0, o_shifter=0, o_valid in the cycle after the accept edge.
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 and new data -> outputs stable, o_ready=0, second word accepted only after the handshake and its result correct.
- Assert i_rst for 1 cycle during SEARCH of 8'b0000_0001 (left) -> IDLE immediately, all outputs 0, no o_valid; next word 8'b0010_0000 gives o_shifter=2.
